// File: rtl/gen_event_unpacker.sv
// Receives 5-beat generated-event records on a 64-bit valid/ready stream,
// validates the header magic and presents each complete event on a valid/ready output.
module gen_event_unpacker #(
    parameter logic [15:0] MAGIC     = 16'hE7E7,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_bits,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_tag,
    output logic [63:0]          out_id,
    output logic [63:0]          out_parent,
    output logic [63:0]          out_cycle,
    output logic [63:0]          out_data,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_HDR,
        S_ID,
        S_PAR,
        S_CYC,
        S_DAT
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] stg_tag;
    logic [63:0] stg_id, stg_par, stg_cyc;
    logic        accept;
    logic        hdr_ok;

    // Only the final beat needs a free output slot; earlier beats stage behind a held event.
    assign in_ready = (state != S_DAT) || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign hdr_ok   = (in_bits[63:48] == MAGIC);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                S_HDR:   state_nxt = hdr_ok ? S_ID : S_HDR;
                S_ID:    state_nxt = S_PAR;
                S_PAR:   state_nxt = S_CYC;
                S_CYC:   state_nxt = S_DAT;
                S_DAT:   state_nxt = S_HDR;
                default: state_nxt = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stg_tag    <= '0;
            stg_id     <= '0;
            stg_par    <= '0;
            stg_cyc    <= '0;
            out_valid  <= 1'b0;
            out_tag    <= '0;
            out_id     <= '0;
            out_parent <= '0;
            out_cycle  <= '0;
            out_data   <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                case (state)
                    S_HDR: begin
                        if (hdr_ok) begin
                            stg_tag <= in_bits[47:32];
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                    end
                    S_ID:  stg_id  <= in_bits;
                    S_PAR: stg_par <= in_bits;
                    S_CYC: stg_cyc <= in_bits;
                    S_DAT: begin
                        // Overrides the clear above so a same-cycle reload leaves no bubble.
                        out_valid  <= 1'b1;
                        out_tag    <= stg_tag;
                        out_id     <= stg_id;
                        out_parent <= stg_par;
                        out_cycle  <= stg_cyc;
                        out_data   <= in_bits;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gen_event_unpacker.sv
// Directed and randomised-gap checks for gen_event_unpacker, including a
// narrow-counter instance for error-count saturation.
module tb_gen_event_unpacker;

    localparam logic [15:0] MAGIC = 16'hE7E7;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_bits;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_tag;
    logic [63:0] out_id, out_parent, out_cycle, out_data;
    logic        err_pulse;
    logic [15:0] err_count;

    logic        in_valid2;
    logic        in_ready2;
    logic [63:0] in_bits2;
    logic        out_valid2;
    logic [15:0] out_tag2;
    logic [63:0] out_id2, out_parent2, out_cycle2, out_data2;
    logic        err_pulse2;
    logic [1:0]  err_count2;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    typedef struct {
        logic [15:0] tag;
        logic [63:0] id, par, cyc, dat;
    } event_t;

    event_t exp_q[$];

    always #5 clock = ~clock;

    gen_event_unpacker #(.MAGIC(MAGIC), .ERR_CNT_W(16)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_id(out_id), .out_parent(out_parent),
        .out_cycle(out_cycle), .out_data(out_data),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    gen_event_unpacker #(.MAGIC(MAGIC), .ERR_CNT_W(2)) u_dut_narrow (
        .clock(clock), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_bits(in_bits2),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_tag(out_tag2), .out_id(out_id2), .out_parent(out_parent2),
        .out_cycle(out_cycle2), .out_data(out_data2),
        .err_pulse(err_pulse2), .err_count(err_count2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [63:0] b);
        logic acc;
        int unsigned budget;
        acc    = 1'b0;
        budget = 0;
        in_valid = 1'b1;
        in_bits  = b;
        while (!acc && budget < 500) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            budget++;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_bits  = '0;
    endtask

    task automatic send_rec(input logic [15:0] tag, input logic [63:0] id, par, cyc, dat);
        send({MAGIC, tag, 32'h0});
        send(id);
        send(par);
        send(cyc);
        send(dat);
    endtask

    task automatic check_event(input string pfx, input logic [15:0] tag,
                               input logic [63:0] id, par, cyc, dat);
        check({pfx, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({pfx, "_tag"}, {48'd0, out_tag}, {48'd0, tag});
        check({pfx, "_id"}, out_id, id);
        check({pfx, "_par"}, out_parent, par);
        check({pfx, "_cyc"}, out_cycle, cyc);
        check({pfx, "_dat"}, out_data, dat);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bits   = '0;
        out_ready = 1'b0;
        in_valid2 = 1'b0;
        in_bits2  = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_err_count", {48'd0, err_count}, 64'd0);
        check("rst_out_id", out_id, 64'd0);

        // Single record, consumer ready
        out_ready = 1'b1;
        send_rec(16'h0005, 64'd1, 64'd0, 64'd100, 64'hAB);
        check_event("t1", 16'h0005, 64'd1, 64'd0, 64'd100, 64'hAB);
        @(posedge clock); #1;
        check("t1_drained", {63'd0, out_valid}, 64'd0);

        // Back-to-back records with consumer stalled
        out_ready = 1'b0;
        send_rec(16'h00A0, 64'hA1, 64'hA2, 64'hA3, 64'hA4);
        send({MAGIC, 16'h00B0, 32'hFFFF_FFFF});
        send(64'hB1);
        send(64'hB2);
        send(64'hB3);
        in_valid = 1'b1;
        in_bits  = 64'hB4;
        @(negedge clock);
        check("t2_stall_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clock); #1;
        check_event("t2_held", 16'h00A0, 64'hA1, 64'hA2, 64'hA3, 64'hA4);
        out_ready = 1'b1;
        @(negedge clock);
        check("t2_pass_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clock); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_event("t2_reload", 16'h00B0, 64'hB1, 64'hB2, 64'hB3, 64'hB4);
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("t2_drained", {63'd0, out_valid}, 64'd0);

        // Bad header dropped
        send(64'h1234_0005_0000_0000);
        check("t3_pulse", {63'd0, err_pulse}, 64'd1);
        check("t3_count", {48'd0, err_count}, 64'd1);
        check("t3_no_event", {63'd0, out_valid}, 64'd0);
        @(posedge clock); #1;
        check("t3_pulse_end", {63'd0, err_pulse}, 64'd0);
        send_rec(16'h0033, 64'h11, 64'h22, 64'h33, 64'h44);
        check_event("t3_rec", 16'h0033, 64'h11, 64'h22, 64'h33, 64'h44);
        @(posedge clock); #1;

        // Saturating 2-bit counter
        in_valid2 = 1'b1;
        in_bits2  = 64'hDEAD_0000_0000_0000;
        for (int unsigned i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check($sformatf("t4_count%0d", i), {62'd0, err_count2}, (i < 3) ? 64'(i + 1) : 64'd3);
        end
        in_valid2 = 1'b0;

        // Reset mid-record
        send({MAGIC, 16'h0077, 32'h0});
        send(64'h77);
        send(64'h78);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("t5_out_valid", {63'd0, out_valid}, 64'd0);
        check("t5_in_ready", {63'd0, in_ready}, 64'd1);
        check("t5_err_count", {48'd0, err_count}, 64'd0);
        check("t5_err_pulse", {63'd0, err_pulse}, 64'd0);
        check("t5_out_tag", {48'd0, out_tag}, 64'd0);
        check("t5_out_data", out_data, 64'd0);
        check("t5_narrow_count", {62'd0, err_count2}, 64'd0);
        send({MAGIC, 16'h0088, 32'h0});
        send(64'h81);
        send(64'h82);
        send(64'h83);
        check("t5_no_stray", {63'd0, out_valid}, 64'd0);
        send(64'h84);
        check_event("t5_rec", 16'h0088, 64'h81, 64'h82, 64'h83, 64'h84);
        @(posedge clock); #1;

        // Random gaps, scoreboard
        fork
            begin
                for (int unsigned r = 0; r < 1000; r++) begin
                    event_t ev;
                    ev.tag = 16'($urandom);
                    ev.id  = {$urandom, $urandom};
                    ev.par = {$urandom, $urandom};
                    ev.cyc = {$urandom, $urandom};
                    ev.dat = {$urandom, $urandom};
                    exp_q.push_back(ev);
                    repeat ($urandom_range(0, 2)) @(posedge clock);
                    #0;
                    send({MAGIC, ev.tag, $urandom});
                    if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
                    send(ev.id);
                    send(ev.par);
                    if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
                    send(ev.cyc);
                    send(ev.dat);
                end
            end
            begin
                int unsigned got_n;
                int unsigned cyc_n;
                got_n = 0;
                cyc_n = 0;
                while (got_n < 1000 && cyc_n < 40000) begin
                    @(negedge clock);
                    if (out_valid && out_ready) begin
                        event_t ev;
                        if (exp_q.size() == 0) begin
                            check("t6_unexpected", 64'd1, 64'd0);
                        end else begin
                            ev = exp_q.pop_front();
                            check("t6_tag", {48'd0, out_tag}, {48'd0, ev.tag});
                            check("t6_id", out_id, ev.id);
                            check("t6_par", out_parent, ev.par);
                            check("t6_cyc", out_cycle, ev.cyc);
                            check("t6_dat", out_data, ev.dat);
                        end
                        got_n++;
                    end
                    @(posedge clock); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    cyc_n++;
                end
                check("t6_received", 64'(got_n), 64'd1000);
            end
        join
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("t6_leftover", 64'(exp_q.size()), 64'd0);
        check("t6_idle", {63'd0, out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
